// File: rtl/lcd_write_buffer_pkg.sv
// lcd_write_buffer_pkg: drain FSM encodings, LCD line codes and entry sizing shared by the write buffer
package lcd_write_buffer_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic LCD_LINE_TOP    = 1'b0;
  localparam logic LCD_LINE_BOTTOM = 1'b1;
  function automatic int lcd_entry_width(input int char_width);
    return char_width + 1;
  endfunction
endpackage

// File: rtl/lcd_write_buffer_fifo.sv
// lcd_write_buffer_fifo: register-array FIFO with flush; count is the single occupancy source
module lcd_write_buffer_fifo #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  drop
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign count   = count_q;
  assign full    = count_q == (ADDR_WIDTH+1)'(DEPTH);
  assign empty   = count_q == '0;
  assign rd_data = mem_q[rd_ptr_q];

  // flush beats push and pop; a pop frees the slot a same-cycle push on full needs
  always_comb begin
    do_pop   = pop && !flush && !empty;
    do_push  = push && !flush && (!full || do_pop);
    drop     = push && !flush && full && !do_pop;
    wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_WIDTH'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_WIDTH'(do_pop);
    count_d  = flush ? '0 : count_q + (ADDR_WIDTH+1)'(do_push) - (ADDR_WIDTH+1)'(do_pop);
  end

  // pointers and count; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end

  // storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
endmodule

// File: rtl/lcd_write_buffer.sv
// lcd_write_buffer: queues CPU LCD writes and drains them to the LCD driver over the flag/done handshake
module lcd_write_buffer
  import lcd_write_buffer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int CHAR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic                  wr_line,
  input  logic [CHAR_WIDTH-1:0] wr_char,
  input  logic                  flush,
  output logic                  lcd_flag,
  output logic                  lcd_line,
  output logic [CHAR_WIDTH-1:0] lcd_char,
  input  logic                  lcd_done,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  stall,
  output logic                  overflow
);
  localparam int ENTRY_WIDTH = lcd_entry_width(CHAR_WIDTH);

  logic                   wr_req_q;
  logic [1:0]             state_q, state_d;
  logic                   lcd_flag_q, lcd_flag_d;
  logic                   lcd_line_q, lcd_line_d;
  logic [CHAR_WIDTH-1:0]  lcd_char_q, lcd_char_d;
  logic                   overflow_q, overflow_d;
  logic                   push, pop, drop;
  logic [ENTRY_WIDTH-1:0] head;

  assign lcd_flag = lcd_flag_q;
  assign lcd_line = lcd_line_q;
  assign lcd_char = lcd_char_q;
  assign overflow = overflow_q;
  assign stall    = full;

  lcd_write_buffer_fifo #(
    .DATA_WIDTH(ENTRY_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .wr_data({wr_line, wr_char}),
    .rd_data(head),
    .count  (count),
    .full   (full),
    .empty  (empty),
    .drop   (drop)
  );

  // one push per wr_req pulse, on its first cycle
  always_comb push = wr_req && !wr_req_q;

  // drain FSM: pop in IDLE, request through ISSUE, wait for done to clear in RELEASE
  always_comb begin
    pop     = state_q == ST_IDLE && !empty && !flush;
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = pop ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   state_d = lcd_done ? ST_RELEASE : ST_ISSUE;
      ST_RELEASE: state_d = lcd_done ? ST_RELEASE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    lcd_flag_d = state_q == ST_ISSUE && !lcd_done;
    lcd_line_d = pop ? (head[CHAR_WIDTH] ? LCD_LINE_BOTTOM : LCD_LINE_TOP) : lcd_line_q;
    lcd_char_d = pop ? head[CHAR_WIDTH-1:0] : lcd_char_q;
    overflow_d = !flush && (overflow_q || drop);
  end

  // output, FSM and edge-detector registers; reset drops lcd_flag immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_req_q   <= 1'b0;
      state_q    <= ST_IDLE;
      lcd_flag_q <= 1'b0;
      lcd_line_q <= LCD_LINE_TOP;
      lcd_char_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_req_q   <= wr_req;
      state_q    <= state_d;
      lcd_flag_q <= lcd_flag_d;
      lcd_line_q <= lcd_line_d;
      lcd_char_q <= lcd_char_d;
      overflow_q <= overflow_d;
    end
endmodule

// File: tb/tb_lcd_write_buffer.sv
// tb_lcd_write_buffer: directed steps with random data against a queue model of pending LCD writes
module tb_lcd_write_buffer;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, wr_req, wr_line, flush, done_man, auto_done, drv_auto;
  logic [7:0] wr_char, lcd_char;
  logic       lcd_done, lcd_flag, lcd_line, full, empty, stall, overflow;
  logic [4:0] count;
  int         n_pass = 0, n_fail = 0, n_total = 0, n_xfer = 0, drv_dly = 3, base;
  bit         exp_ovf = 1'b0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;
  assign lcd_done = drv_auto ? auto_done : done_man;

  lcd_write_buffer dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_line(wr_line), .wr_char(wr_char),
    .flush(flush), .lcd_flag(lcd_flag), .lcd_line(lcd_line), .lcd_char(lcd_char),
    .lcd_done(lcd_done), .full(full), .empty(empty), .count(count), .stall(stall),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one processor write; the model queues it unless flushed or the buffer is full with no pop
  task automatic wr(input logic ln, input logic [7:0] ch, input bit pop_now = 1'b0);
    wr_req = 1'b1; wr_line = ln; wr_char = ch;
    if (!flush) begin
      if (exp_q.size() < DEPTH || pop_now) exp_q.push_back({ln, ch});
      else exp_ovf = 1'b1;
    end
    @(negedge clk); wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || lcd_flag || lcd_done || !empty) && n < budget) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    chk("drain_done", 32'(n < budget), 32'd1);
  endtask

  // LCD driver: raises done drv_dly cycles after seeing the flag, drops it once the flag falls
  initial begin
    int w;
    w = 0; auto_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !drv_auto) begin auto_done = 1'b0; w = 0; end
      else if (lcd_flag && !auto_done) begin
        if (w >= drv_dly) auto_done = 1'b1; else w++;
      end else if (!lcd_flag && auto_done) begin auto_done = 1'b0; w = 0; end
    end
  end

  // scoreboard: each flag rise must present the oldest pending write, held until the handshake ends
  initial begin
    logic prev, act;
    logic [8:0] hold;
    prev = 1'b0; act = 1'b0; hold = '0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin prev = 1'b0; act = 1'b0; end
      else begin
        if (lcd_flag && !prev) begin
          n_xfer++;
          chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("order", 32'({lcd_line, lcd_char}), 32'(exp_q.pop_front()));
          hold = {lcd_line, lcd_char};
          act = 1'b1;
        end else if (act) begin
          chk("hold", 32'({lcd_line, lcd_char}), 32'(hold));
          if (!lcd_flag && !lcd_done) act = 1'b0;
        end
        prev = lcd_flag;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wr_req = 1'b0; wr_line = 1'b0; wr_char = '0; flush = 1'b0;
    done_man = 1'b0; drv_auto = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_flag", 32'(lcd_flag), 32'd0);
    chk("rst_line", 32'(lcd_line), 32'd0);
    chk("rst_char", 32'(lcd_char), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single write held for 40 cycles: latency and exactly one transfer
    base = n_xfer;
    wr_req = 1'b1; wr_line = 1'b1; wr_char = 8'h41; exp_q.push_back(9'h141);
    @(negedge clk);
    chk("t1_count_k", 32'(count), 32'(exp_q.size()));
    chk("t1_flag_k", 32'(lcd_flag), 32'd0);
    @(negedge clk);
    chk("t1_flag_k1", 32'(lcd_flag), 32'd0);
    chk("t1_count_k1", 32'(count), 32'd0);
    chk("t1_char_k1", 32'({lcd_line, lcd_char}), 32'h141);
    @(negedge clk);
    chk("t1_flag_k2", 32'(lcd_flag), 32'd1);
    drv_dly = int'($urandom_range(0, 4)); drv_auto = 1'b1;
    repeat (37) @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    chk("t1_one_xfer", 32'(n_xfer - base), 32'd1);
    chk("t1_count_end", 32'(count), 32'd0);
    chk("t1_empty_end", 32'(empty), 32'd1);

    // burst to full with the driver stalled, then one dropped write
    drv_auto = 1'b0; done_man = 1'b0;
    for (int i = 0; i < 16; i++) wr(1'($urandom_range(0, 1)), 8'(8'h30 + i));
    chk("t2_flag", 32'(lcd_flag), 32'd1);
    chk("t2_inflight", 32'(lcd_char), 32'h30);
    chk("t2_count15", 32'(count), 32'(exp_q.size()));
    chk("t2_notfull", 32'(full), 32'd0);
    wr(1'($urandom_range(0, 1)), 8'h40);
    chk("t2_count16", 32'(count), 32'(exp_q.size()));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_stall", 32'(stall), 32'd1);
    chk("t2_no_ovf", 32'(overflow), 32'(exp_ovf));
    wr(1'($urandom_range(0, 1)), 8'h41);
    chk("t2_ovf", 32'(overflow), 32'(exp_ovf));
    chk("t2_count_kept", 32'(count), 32'd16);

    // flush while a transfer is in ISSUE clears queue and overflow only
    flush = 1'b1; exp_q.delete(); exp_ovf = 1'b0;
    @(negedge clk); flush = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_ovf", 32'(overflow), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_flag_kept", 32'(lcd_flag), 32'd1);

    // refill, then make a pop and a push land on the same edge
    for (int i = 0; i < 16; i++) wr(1'($urandom_range(0, 1)), 8'($urandom));
    chk("t3_count16", 32'(count), 32'(exp_q.size()));
    chk("t3_full", 32'(full), 32'd1);
    done_man = 1'b1;
    @(negedge clk);
    chk("t3_flag_drop", 32'(lcd_flag), 32'd0);
    done_man = 1'b0;
    @(negedge clk);
    wr(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    chk("t3_count_same", 32'(count), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_full_kept", 32'(full), 32'd1);
    base = n_xfer;
    drv_dly = int'($urandom_range(0, 4)); drv_auto = 1'b1;
    drain(3000);
    chk("t3_xfers", 32'(n_xfer - base), 32'd16);
    chk("t3_count_end", 32'(count), 32'd0);

    // ordering with a 3-cycle driver and random gaps between writes
    drv_dly = 3; base = n_xfer;
    for (int i = 0; i < 5; i++) begin
      wr(1'($urandom_range(0, 1)), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(1000);
    chk("t4_xfers", 32'(n_xfer - base), 32'd5);
    chk("t4_count", 32'(count), 32'd0);

    // flush mid-transfer with a coincident write: transfer finishes, nothing follows
    drv_auto = 1'b0; done_man = 1'b0;
    for (int i = 0; i < 5; i++) wr(1'($urandom_range(0, 1)), 8'($urandom));
    chk("t5_flag", 32'(lcd_flag), 32'd1);
    chk("t5_count4", 32'(count), 32'(exp_q.size()));
    flush = 1'b1; exp_q.delete(); exp_ovf = 1'b0;
    wr_req = 1'b1; wr_char = 8'($urandom);
    @(negedge clk); flush = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    chk("t5_count0", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_ovf", 32'(overflow), 32'(exp_ovf));
    chk("t5_flag_kept", 32'(lcd_flag), 32'd1);
    base = n_xfer;
    done_man = 1'b1;
    repeat (2) @(negedge clk);
    done_man = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_no_more", 32'(n_xfer - base), 32'd0);
    chk("t5_flag_end", 32'(lcd_flag), 32'd0);

    // asynchronous reset between edges while in ISSUE
    for (int i = 0; i < 3; i++) wr(1'($urandom_range(0, 1)), 8'($urandom));
    chk("t6_flag", 32'(lcd_flag), 32'd1);
    chk("t6_count2", 32'(count), 32'(exp_q.size()));
    #2 reset = 1'b1;
    #1;
    exp_q.delete(); exp_ovf = 1'b0;
    chk("t6_flag_async", 32'(lcd_flag), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_char", 32'({lcd_line, lcd_char}), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    @(negedge clk); reset = 1'b0;
    done_man = 1'b0; drv_auto = 1'b1; base = n_xfer;
    wr(1'($urandom_range(0, 1)), 8'($urandom));
    drain(500);
    chk("t6_after", 32'(n_xfer - base), 32'd1);
    chk("t6_count_end", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
